lab3_test_sequencer: RTL and testbench
======================================

# lab3_test_sequencer

Hardware stimulus/check sequencer for the lab3 signal-analysis parts (three combinational circuits, D flip-flop, JK flip-flop, state+logic circuit). It fetches test vectors from an external synchronous-read memory and drives inputs and reset to the selected part. It waits a programmable number of settle clocks, then compares the part's output against the expected value under a mask. It reports pass/fail, mismatch count and first failing index, so lab checks run on the board without a simulator.

## Interface
- SETTLE_CYCLES, 1, clocks between applying a vector and sampling; legal range 1..15
- ADDR_W, 5, vector memory address width
- CNT_W, 5, fail counter width
- clk  in  1  system clock; every DUT part shares it
- reset  in  1  synchronous, active-high
- start  in  1  pulse; begins a run when sampled in IDLE
- vec_addr  out  ADDR_W  vector memory address
- vec_data  in  14  vector word, valid one cycle after vec_addr: [13] last, [12:10] part, [9] rst, [8:5] in {a,b,c,d}, [4] chk, [3:2] exp, [1:0] mask
- dut_sel  out  3  selected part (1..6), 0 when idle
- dut_rst  out  1  reset driven to the sequential parts
- dut_in  out  4  stimulus {a,b,c,d}; sequential parts use the low bits (d; j,k; a,b)
- dut_out  in  2  response of selected part ({state,y} or {0,q}/{0,y}), muxed externally by dut_sel
- busy  out  1  run in progress
- done  out  1  run finished; held until next start or reset
- pass  out  1  done and zero mismatches
- fail_count  out  CNT_W  mismatch count, saturating at 2^CNT_W-1
- first_fail_idx  out  ADDR_W  address of first mismatch, valid when fail_count != 0

## Operation
- Reset values:
  - dut_rst = 1
  - vec_addr, dut_sel, dut_in, busy, done, pass, fail_count, first_fail_idx = 0
  - state = IDLE
- States:
  - IDLE: dut_rst = 1. On start go to FETCH and:
    - busy = 1
    - done = pass = 0
    - fail_count = first_fail_idx = 0
    - vec_addr = 0
  - FETCH: vec_addr is stable; the memory read is in flight. Go to APPLY.
  - APPLY: vec_data is valid. Latch its fields; register dut_sel, dut_rst and dut_in at this edge. Load the settle counter with SETTLE_CYCLES. Go to SETTLE.
  - SETTLE: decrement the counter. At 1, go to CHECK.
  - CHECK: mismatch = chk && ((dut_out ^ exp) & mask) != 0.
    - On the first mismatch, capture vec_addr into first_fail_idx.
    - On every mismatch, increment fail_count (saturating).
    - If last, or vec_addr = 2^ADDR_W-1: go to IDLE; busy = 0, done = 1, pass = (final fail_count == 0); dut_sel = 0, dut_in = 0, dut_rst = 1.
    - Otherwise: vec_addr + 1, go to FETCH.
- start while busy: ignored. start in IDLE with done = 1: starts a new run and clears the results.
- chk = 0 vectors only apply stimulus, e.g. hold reset or clock in state.
- Reset mid-run: next cycle all outputs are at their reset values; no partial results are retained.

## Timing
- Let start be sampled at edge E0:
  - busy rises at E0.
  - dut_* load at E2.
  - The DUT sees SETTLE_CYCLES rising edges with the new stimulus before sampling.
  - dut_out is sampled at edge E(3+SETTLE_CYCLES).
- Per vector: SETTLE_CYCLES+3 cycles. K-vector run: busy high for K*(SETTLE_CYCLES+3) cycles.
- done, pass and busy update on the same edge as the final CHECK.
- No combinational path from any input to any output.

## Structure
- Package lab3_seq_pkg:
  - state enum (IDLE, FETCH, APPLY, SETTLE, CHECK)
  - VEC_W = 14 and the bit-field offsets of the vector word
  - part codes 1..6
- Single module; no sub-module. The vector memory and the dut_out mux live outside the block.

## Test plan
- Loopback bench (dut_out = dut_in[1:0]), SETTLE_CYCLES = 1. Single vector: last = 1, part = 1, in = 0011, chk = 1, exp = 11, mask = 11 -> busy high exactly 4 cycles, done = 1, pass = 1, fail_count = 0.
- Loopback bench, three vectors; vector 1 has exp = 01 against a response of 11 -> fail_count = 1, first_fail_idx = 1, pass = 0, vec_addr stops at 2.
- Mismatching vector with mask = 00, then one with chk = 0 -> fail_count = 0, pass = 1.
- D flip-flop model:
  - Vectors: (rst = 1, chk = 0), (rst = 0, d = 0, exp = 00, mask = 01), (d = 1, exp = 01), (d = 0, exp = 00).
  - Required: pass = 1.
  - Rerun with SETTLE_CYCLES = 3 -> identical results, busy = 24 cycles.
- Start pulses while busy are ignored. Reset asserted in SETTLE of vector 2 -> next cycle busy = 0, dut_rst = 1, fail_count = 0, done = 0.
- Memory with no last bit in any of the 32 entries, loopback matching -> run ends after address 31 with done = 1, pass = 1, busy high 128 cycles.
- Loopback bench, 33 mismatching vectors with CNT_W = 5 (needs ADDR_W = 6) -> fail_count saturates at 31, first_fail_idx = 0.

Source files
------------

// File: rtl/lab3_seq_pkg.sv
// Shared definitions for the lab3 test sequencer: FSM states, the vector word
// layout, and the part-select codes driven on dut_sel.
package lab3_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_APPLY,
        S_SETTLE,
        S_CHECK
    } seq_state_e;

    localparam int VEC_W        = 14;
    localparam int VEC_LAST_BIT = 13;
    localparam int VEC_PART_LSB = 10;
    localparam int VEC_PART_W   = 3;
    localparam int VEC_RST_BIT  = 9;
    localparam int VEC_IN_LSB   = 5;
    localparam int VEC_IN_W     = 4;
    localparam int VEC_CHK_BIT  = 4;
    localparam int VEC_EXP_LSB  = 2;
    localparam int VEC_MASK_LSB = 0;

    localparam logic [2:0] PART_NONE  = 3'd0;
    localparam logic [2:0] PART_COMB1 = 3'd1;
    localparam logic [2:0] PART_COMB2 = 3'd2;
    localparam logic [2:0] PART_COMB3 = 3'd3;
    localparam logic [2:0] PART_DFF   = 3'd4;
    localparam logic [2:0] PART_JKFF  = 3'd5;
    localparam logic [2:0] PART_STATE = 3'd6;

endpackage

// File: rtl/lab3_test_sequencer.sv
// Fetches test vectors from an external synchronous-read memory, drives the
// selected lab3 part, waits SETTLE_CYCLES clocks and checks its masked response.
module lab3_test_sequencer
    import lab3_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int ADDR_W        = 5,
    parameter int CNT_W         = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] vec_addr,
    input  logic [VEC_W-1:0]  vec_data,
    output logic [2:0]        dut_sel,
    output logic              dut_rst,
    output logic [3:0]        dut_in,
    input  logic [1:0]        dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  fail_count,
    output logic [ADDR_W-1:0] first_fail_idx
);

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

    seq_state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        sel_q, sel_d;
    logic              rst_q, rst_d;
    logic [3:0]        in_q, in_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [CNT_W-1:0]  fc_q, fc_d;
    logic [ADDR_W-1:0] ffi_q, ffi_d;
    logic [3:0]        cnt_q, cnt_d;

    logic       last_q, chk_q;
    logic [1:0] exp_q, mask_q;

    logic mismatch;
    logic end_run;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign mismatch = chk_q && (((dut_out ^ exp_q) & mask_q) != 2'b00);
    assign end_run  = last_q || (addr_q == '1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            sel_q   <= PART_NONE;
            rst_q   <= 1'b1;
            in_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fc_q    <= '0;
            ffi_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            rst_q   <= rst_d;
            in_q    <= in_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fc_q    <= fc_d;
            ffi_q   <= ffi_d;
            cnt_q   <= cnt_d;
        end
    end

    // Check fields are consumed only in CHECK, always after an APPLY reload.
    always_ff @(posedge clk) begin
        if (state_q == S_APPLY) begin
            last_q <= vec_data[VEC_LAST_BIT];
            chk_q  <= vec_data[VEC_CHK_BIT];
            exp_q  <= vec_data[VEC_EXP_LSB +: 2];
            mask_q <= vec_data[VEC_MASK_LSB +: 2];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH:  state_d = S_APPLY;
            S_APPLY:  state_d = S_SETTLE;
            S_SETTLE: if (cnt_q <= 4'd1) state_d = S_CHECK;
            S_CHECK:  state_d = end_run ? S_IDLE : S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_d = addr_q;
        sel_d  = sel_q;
        rst_d  = rst_q;
        in_d   = in_q;
        busy_d = busy_q;
        done_d = done_q;
        pass_d = pass_q;
        fc_d   = fc_q;
        ffi_d  = ffi_q;
        cnt_d  = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                rst_d = 1'b1;
                if (start) begin
                    busy_d = 1'b1;
                    done_d = 1'b0;
                    pass_d = 1'b0;
                    fc_d   = '0;
                    ffi_d  = '0;
                    addr_d = '0;
                end
            end
            S_APPLY: begin
                sel_d = vec_data[VEC_PART_LSB +: VEC_PART_W];
                rst_d = vec_data[VEC_RST_BIT];
                in_d  = vec_data[VEC_IN_LSB +: VEC_IN_W];
                cnt_d = SETTLE_LD;
            end
            S_SETTLE: cnt_d = cnt_q - 4'd1;
            S_CHECK: begin
                if (mismatch) begin
                    fc_d = sat_inc(fc_q);
                    if (fc_q == '0) ffi_d = addr_q;
                end
                if (end_run) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    pass_d = (fc_d == '0);
                    sel_d  = PART_NONE;
                    in_d   = '0;
                    rst_d  = 1'b1;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign vec_addr       = addr_q;
    assign dut_sel        = sel_q;
    assign dut_rst        = rst_q;
    assign dut_in         = in_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign fail_count     = fc_q;
    assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_lab3_test_sequencer.sv
// Scoreboard bench: two sequencer instances (settle 1 / 5-bit address and
// settle 3 / 6-bit address) with behavioural vector memories and part models.
module tb_lab3_test_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start_a, start_b;

    logic [4:0]  vec_addr_a, ffi_a, fc_a;
    logic [13:0] vec_data_a;
    logic [2:0]  sel_a;
    logic        drst_a, busy_a, done_a, pass_a;
    logic [3:0]  din_a;
    logic [1:0]  dout_a;

    logic [5:0]  vec_addr_b, ffi_b;
    logic [4:0]  fc_b;
    logic [13:0] vec_data_b;
    logic [2:0]  sel_b;
    logic        drst_b, busy_b, done_b, pass_b;
    logic [3:0]  din_b;
    logic [1:0]  dout_b;

    logic [13:0] mem_a [32];
    logic [13:0] mem_b [64];
    logic        mode_a, mode_b;
    logic        q_a, q_b;

    lab3_test_sequencer #(.SETTLE_CYCLES(1), .ADDR_W(5), .CNT_W(5)) dut_a (
        .clk(clk), .reset(reset), .start(start_a),
        .vec_addr(vec_addr_a), .vec_data(vec_data_a),
        .dut_sel(sel_a), .dut_rst(drst_a), .dut_in(din_a), .dut_out(dout_a),
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .fail_count(fc_a), .first_fail_idx(ffi_a)
    );

    lab3_test_sequencer #(.SETTLE_CYCLES(3), .ADDR_W(6), .CNT_W(5)) dut_b (
        .clk(clk), .reset(reset), .start(start_b),
        .vec_addr(vec_addr_b), .vec_data(vec_data_b),
        .dut_sel(sel_b), .dut_rst(drst_b), .dut_in(din_b), .dut_out(dout_b),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .fail_count(fc_b), .first_fail_idx(ffi_b)
    );

    // Synchronous-read memories and the parts under test: loopback or D flip-flop.
    always @(posedge clk) vec_data_a <= mem_a[vec_addr_a];
    always @(posedge clk) vec_data_b <= mem_b[vec_addr_b];
    always @(posedge clk) q_a <= drst_a ? 1'b0 : din_a[0];
    always @(posedge clk) q_b <= drst_b ? 1'b0 : din_b[0];
    assign dout_a = mode_a ? {1'b0, q_a} : din_a[1:0];
    assign dout_b = mode_b ? {1'b0, q_b} : din_b[1:0];

    typedef struct {
        int p;
        int fc;
        int ffi;
        int addr;
        int busy;
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_b[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [13:0] v(input logic last, input logic [2:0] part,
                                      input logic rst, input logic [3:0] din,
                                      input logic chk_b, input logic [1:0] ex,
                                      input logic [1:0] mask);
        return {last, part, rst, din, chk_b, ex, mask};
    endfunction

    task automatic clear_mems();
        for (int i = 0; i < 32; i++) mem_a[i] = '0;
        for (int i = 0; i < 64; i++) mem_b[i] = '0;
    endtask

    // Monitors: on each rising done, pop the expected run result and compare.
    initial begin
        int bc = 0;
        logic dp = 1'b0, bp = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy_a && !bp) bc = 1;
            else if (busy_a) bc++;
            if (done_a && !dp) begin
                if (exp_a.size() == 0) begin
                    chk("a_unexpected_done", 1, 0);
                end else begin
                    e = exp_a.pop_front();
                    chk("a_pass", int'(pass_a), e.p);
                    chk("a_fail_count", int'(fc_a), e.fc);
                    chk("a_first_fail_idx", int'(ffi_a), e.ffi);
                    chk("a_vec_addr", int'(vec_addr_a), e.addr);
                    chk("a_busy_cycles", bc, e.busy);
                    chk("a_busy_end", int'(busy_a), 0);
                    chk("a_sel_end", int'(sel_a), 0);
                    chk("a_in_end", int'(din_a), 0);
                    chk("a_rst_end", int'(drst_a), 1);
                end
            end
            dp = done_a;
            bp = busy_a;
        end
    end

    initial begin
        int bc = 0;
        logic dp = 1'b0, bp = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy_b && !bp) bc = 1;
            else if (busy_b) bc++;
            if (done_b && !dp) begin
                if (exp_b.size() == 0) begin
                    chk("b_unexpected_done", 1, 0);
                end else begin
                    e = exp_b.pop_front();
                    chk("b_pass", int'(pass_b), e.p);
                    chk("b_fail_count", int'(fc_b), e.fc);
                    chk("b_first_fail_idx", int'(ffi_b), e.ffi);
                    chk("b_vec_addr", int'(vec_addr_b), e.addr);
                    chk("b_busy_cycles", bc, e.busy);
                    chk("b_rst_end", int'(drst_b), 1);
                end
            end
            dp = done_b;
            bp = busy_b;
        end
    end

    task automatic run_a(input int p, input int fc, input int ffi, input int addr,
                         input int busy_cyc, input int pulses);
        exp_t e;
        int n;
        e.p = p; e.fc = fc; e.ffi = ffi; e.addr = addr; e.busy = busy_cyc;
        exp_a.push_back(e);
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        for (int k = 0; k < pulses; k++) begin
            repeat (3) @(negedge clk);
            start_a = 1'b1;
            @(negedge clk); start_a = 1'b0;
        end
        n = 0;
        while (!done_a && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!done_a) chk("a_timeout", 1, 0);
    endtask

    task automatic run_b(input int p, input int fc, input int ffi, input int addr,
                         input int busy_cyc);
        exp_t e;
        int n;
        e.p = p; e.fc = fc; e.ffi = ffi; e.addr = addr; e.busy = busy_cyc;
        exp_b.push_back(e);
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        n = 0;
        while (!done_b && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!done_b) chk("b_timeout", 1, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
        mode_a = 1'b0; mode_b = 1'b0;
        clear_mems();
        repeat (3) @(negedge clk);
        chk("rst_dut_rst", int'(drst_a), 1);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_pass", int'(pass_a), 0);
        chk("rst_fail_count", int'(fc_a), 0);
        chk("rst_first_fail_idx", int'(ffi_a), 0);
        chk("rst_vec_addr", int'(vec_addr_a), 0);
        chk("rst_dut_sel", int'(sel_a), 0);
        chk("rst_dut_in", int'(din_a), 0);
        chk("rst_b_dut_rst", int'(drst_b), 1);
        reset = 1'b0;
        @(negedge clk);

        // Single matching loopback vector: 4 busy cycles.
        mem_a[0] = v(1, 3'd1, 0, 4'b0011, 1, 2'b11, 2'b11);
        run_a(1, 0, 0, 0, 4, 0);

        // Vector 1 expects 01 but loopback returns 11.
        clear_mems();
        mem_a[0] = v(0, 3'd1, 0, 4'b0001, 1, 2'b01, 2'b11);
        mem_a[1] = v(0, 3'd2, 0, 4'b0011, 1, 2'b01, 2'b11);
        mem_a[2] = v(1, 3'd3, 0, 4'b0010, 1, 2'b10, 2'b11);
        run_a(0, 1, 1, 2, 12, 0);

        // Masked-out mismatch, then a stimulus-only vector.
        clear_mems();
        mem_a[0] = v(0, 3'd1, 0, 4'b0011, 1, 2'b00, 2'b00);
        mem_a[1] = v(1, 3'd1, 0, 4'b0000, 0, 2'b11, 2'b11);
        run_a(1, 0, 0, 1, 8, 0);

        // D flip-flop sequence, with start pulses while busy.
        clear_mems();
        mode_a = 1'b1;
        mem_a[0] = v(0, 3'd4, 1, 4'b0000, 0, 2'b00, 2'b00);
        mem_a[1] = v(0, 3'd4, 0, 4'b0000, 1, 2'b00, 2'b01);
        mem_a[2] = v(0, 3'd4, 0, 4'b0001, 1, 2'b01, 2'b01);
        mem_a[3] = v(1, 3'd4, 0, 4'b0000, 1, 2'b00, 2'b01);
        run_a(1, 0, 0, 3, 16, 2);

        // Same D flip-flop vectors with three settle clocks.
        mode_b = 1'b1;
        for (int i = 0; i < 4; i++) mem_b[i] = mem_a[i];
        run_b(1, 0, 0, 3, 24);

        // Reset during SETTLE of vector 2 discards the partial run.
        clear_mems();
        mode_a = 1'b0;
        mem_a[0] = v(0, 3'd1, 0, 4'b0011, 1, 2'b00, 2'b11);
        mem_a[1] = v(0, 3'd1, 0, 4'b0001, 1, 2'b01, 2'b11);
        mem_a[2] = v(1, 3'd1, 0, 4'b0001, 1, 2'b01, 2'b11);
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_vec_addr", int'(vec_addr_a), 1);
        chk("mid_fail_count", int'(fc_a), 1);
        chk("mid_busy", int'(busy_a), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", int'(busy_a), 0);
        chk("abort_dut_rst", int'(drst_a), 1);
        chk("abort_fail_count", int'(fc_a), 0);
        chk("abort_done", int'(done_a), 0);
        chk("abort_first_fail_idx", int'(ffi_a), 0);
        chk("abort_vec_addr", int'(vec_addr_a), 0);
        chk("abort_dut_sel", int'(sel_a), 0);
        @(negedge clk);

        // No last bit anywhere: run ends after address 31.
        for (int i = 0; i < 32; i++) begin
            logic [3:0] d4;
            d4 = 4'(i);
            mem_a[i] = v(0, 3'd2, 0, d4, 1, d4[1:0], 2'b11);
        end
        run_a(1, 0, 0, 31, 128, 0);

        // 33 mismatching vectors saturate the 5-bit fail counter.
        clear_mems();
        mode_b = 1'b0;
        for (int i = 0; i < 33; i++) mem_b[i] = v(i == 32, 3'd1, 0, 4'b0000, 1, 2'b11, 2'b11);
        run_b(0, 31, 0, 32, 198);

        repeat (4) @(negedge clk);
        chk("a_queue_left", exp_a.size(), 0);
        chk("b_queue_left", exp_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
